// File: rtl/manual_clock_stepper.sv
// manual_clock_stepper: turns the manual-clock latch into one-cycle core step enables.
// It supports single step, hold-to-repeat and free-run at a programmable divide.
module manual_clock_stepper #(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000,
    parameter int          DIV_W         = 24
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             Latch_Q,
    input  logic             Run_Mode,
    input  logic             Repeat_En,
    input  logic [DIV_W-1:0] Run_Div,
    output logic             Step_Pulse,
    output logic [15:0]      Step_Count,
    output logic             Held,
    output logic             Running
);
    typedef enum logic [2:0] {S_ARM, S_IDLE, S_HOLD, S_REPEAT, S_RUN} state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] q_sync_q, q_sync_d, r_sync_q, r_sync_d, valid_q, valid_d;
    logic                   pulse_q, pulse_d, running_q, running_d;
    logic [15:0]            count_q, count_d;
    logic [23:0]            dly_q, dly_d, per_q, per_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   q_s, r_s;

    assign q_s        = q_sync_q[SYNC_STAGES-1];
    assign r_s        = r_sync_q[SYNC_STAGES-1];
    assign Step_Pulse = pulse_q;
    assign Step_Count = count_q;
    assign Held       = q_s;
    assign Running    = running_q;

    // valid_q fills with ones after reset so ARM only trusts q_s once it holds a real sample
    always_comb begin
        q_sync_d = {q_sync_q[SYNC_STAGES-2:0], Latch_Q};
        r_sync_d = {r_sync_q[SYNC_STAGES-2:0], Run_Mode};
        valid_d  = {valid_q[SYNC_STAGES-2:0], 1'b1};
        state_d  = state_q;
        pulse_d  = 1'b0;
        dly_d    = dly_q;
        per_d    = per_q;
        div_d    = div_q;
        unique case (state_q)
            S_ARM: begin
                if (r_s) state_d = S_RUN;
                else if (valid_q[SYNC_STAGES-1] && !q_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (r_s) state_d = S_RUN;
                else if (q_s) begin
                    state_d = S_HOLD;
                    pulse_d = 1'b1;
                    dly_d   = REPEAT_DELAY - 24'd1;
                end
            end
            S_HOLD: begin
                if (r_s) state_d = S_RUN;
                else if (!q_s) state_d = S_IDLE;
                else if (Repeat_En) begin
                    if (dly_q == 24'd0) begin
                        state_d = S_REPEAT;
                        pulse_d = 1'b1;
                        per_d   = REPEAT_PERIOD - 24'd1;
                    end else dly_d = dly_q - 24'd1;
                end
            end
            S_REPEAT: begin
                if (r_s) state_d = S_RUN;
                else if (!q_s) state_d = S_IDLE;
                else if (!Repeat_En) state_d = S_ARM;
                else if (per_q == 24'd0) begin
                    pulse_d = 1'b1;
                    per_d   = REPEAT_PERIOD - 24'd1;
                end else per_d = per_q - 24'd1;
            end
            S_RUN: begin
                if (!r_s) begin
                    state_d = S_ARM;
                    div_d   = '0;
                end else if (div_q == Run_Div) begin
                    pulse_d = 1'b1;
                    div_d   = '0;
                end else div_d = div_q + DIV_ONE;
            end
            default: state_d = S_ARM;
        endcase
        count_d   = count_q + {15'd0, pulse_d};
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= S_ARM;
            q_sync_q  <= '0;
            r_sync_q  <= '0;
            valid_q   <= '0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
            dly_q     <= '0;
            per_q     <= '0;
            div_q     <= '0;
        end else begin
            state_q   <= state_d;
            q_sync_q  <= q_sync_d;
            r_sync_q  <= r_sync_d;
            valid_q   <= valid_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            count_q   <= count_d;
            dly_q     <= dly_d;
            per_q     <= per_d;
            div_q     <= div_d;
        end
    end
endmodule

// File: tb/tb_manual_clock_stepper.sv
// tb_manual_clock_stepper: vector table, directed corner sequences and a randomized run
// checked against a behavioural model of the stepper.
module tb_manual_clock_stepper;
    localparam int DW = 24;
    localparam int S  = 2;
    localparam int D  = 8;
    localparam int P  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          latch_q = 1'b0;
    logic          run_mode = 1'b0;
    logic          repeat_en = 1'b0;
    logic [DW-1:0] run_div = '0;
    logic          step_pulse;
    logic [15:0]   step_count;
    logic          held;
    logic          running;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    manual_clock_stepper #(
        .SYNC_STAGES(S),
        .REPEAT_DELAY(24'(D)),
        .REPEAT_PERIOD(24'(P)),
        .DIV_W(DW)
    ) dut (
        .Clk(clk),
        .Reset_N(rst_n),
        .Latch_Q(latch_q),
        .Run_Mode(run_mode),
        .Repeat_En(repeat_en),
        .Run_Div(run_div),
        .Step_Pulse(step_pulse),
        .Step_Count(step_count),
        .Held(held),
        .Running(running)
    );

    // Model: phase 0 waits for a release, 1 ready, 2 button held (n = enabled cycles since press), 3 run
    logic [S-1:0]  mq, mr;
    int            phase, n, since_rst;
    logic [DW-1:0] k;
    logic          m_pulse;
    logic [15:0]   m_count;

    function automatic void model_reset();
        mq = '0;
        mr = '0;
        phase = 0;
        n = 0;
        since_rst = 0;
        k = '0;
        m_pulse = 1'b0;
        m_count = '0;
    endfunction

    task automatic model_step();
        logic qs, rs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        qs = mq[S-1];
        rs = mr[S-1];
        m_pulse = 1'b0;
        if (rs) begin
            if (phase != 3) begin
                phase = 3;
                k = '0;
            end else if (k == run_div) begin
                m_pulse = 1'b1;
                k = '0;
            end else k = k + 24'd1;
        end else begin
            case (phase)
                3: begin
                    phase = 0;
                    k = '0;
                end
                0: if (since_rst >= S && !qs) phase = 1;
                1: if (qs) begin
                    m_pulse = 1'b1;
                    phase = 2;
                    n = 0;
                end
                default: begin
                    if (!qs) phase = 1;
                    else if (repeat_en) begin
                        n++;
                        m_pulse = (n == D) || (n > D && (n - D) % P == 0);
                    end else if (n >= D) phase = 0;
                end
            endcase
        end
        m_count = m_count + 16'(m_pulse);
        mq = {mq[S-2:0], latch_q};
        mr = {mr[S-2:0], run_mode};
        since_rst++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic count_pulses(input int cycles, output int np);
        np = 0;
        repeat (cycles) begin
            cyc();
            if (step_pulse) np++;
        end
    endtask

    typedef struct {
        logic        l, r;
        logic        p, h, run;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic l, r, p, h, run, input logic [15:0] cnt);
        vec_t v;
        v.l = l; v.r = r; v.p = p; v.h = h; v.run = run; v.cnt = cnt;
        return v;
    endfunction

    vec_t tv[30];

    initial begin
        int got[$];
        int want[$];
        int np;
        tv[0] = mk(0, 0, 0, 0, 0, 0);
        tv[1] = mk(0, 0, 0, 0, 0, 0);
        tv[2] = mk(1, 0, 0, 0, 0, 0);
        tv[3] = mk(1, 0, 0, 1, 0, 0);
        tv[4] = mk(1, 0, 1, 1, 0, 1);
        for (int i = 5; i < 12; i++) tv[i] = mk(1, 0, 0, 1, 0, 1);
        tv[12] = mk(0, 0, 0, 1, 0, 1);
        tv[13] = mk(0, 0, 0, 0, 0, 1);
        tv[14] = mk(0, 0, 0, 0, 0, 1);
        tv[15] = mk(0, 1, 0, 0, 0, 1);
        tv[16] = mk(0, 1, 0, 0, 0, 1);
        for (int i = 17; i < 21; i++) tv[i] = mk(0, 1, 0, 0, 1, 1);
        tv[21] = mk(0, 1, 1, 0, 1, 2);
        for (int i = 22; i < 25; i++) tv[i] = mk(0, 1, 0, 0, 1, 2);
        tv[25] = mk(0, 1, 1, 0, 1, 3);
        tv[26] = mk(0, 0, 0, 0, 1, 3);
        tv[27] = mk(0, 0, 0, 0, 1, 3);
        tv[28] = mk(0, 0, 0, 0, 0, 3);
        tv[29] = mk(0, 0, 0, 0, 0, 3);
        model_reset();
        run_div = 24'd3;

        repeat (2) cyc();
        chk("reset_pulse", 32'(step_pulse), 32'd0);
        chk("reset_count", 32'(step_count), 32'd0);
        chk("reset_held", 32'(held), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            latch_q = tv[i].l;
            run_mode = tv[i].r;
            cyc();
            chk($sformatf("row%0d_pulse", i), 32'(step_pulse), 32'(tv[i].p));
            chk($sformatf("row%0d_held", i), 32'(held), 32'(tv[i].h));
            chk($sformatf("row%0d_running", i), 32'(running), 32'(tv[i].run));
            chk($sformatf("row%0d_count", i), 32'(step_count), 32'(tv[i].cnt));
        end

        // hold-to-repeat: 30-cycle press then release
        repeat_en = 1'b1;
        repeat (3) cyc();
        for (int t = 0; t < 36; t++) begin
            latch_q = (t < 30);
            cyc();
            if (step_pulse) got.push_back(t);
        end
        want.push_back(2);
        for (int m = 1; m < 30; m++)
            if (m == D || (m > D && (m - D) % P == 0)) want.push_back(2 + m);
        chk("repeat_npulses", 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("repeat_t%0d", i), i < got.size() ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want[i]));

        // button held through reset
        latch_q = 1'b1;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        count_pulses(20, np);
        chk("held_rst_nopulse", 32'(np), 32'd0);
        chk("held_rst_held", 32'(held), 32'd1);
        latch_q = 1'b0;
        count_pulses(4, np);
        latch_q = 1'b1;
        count_pulses(6, np);
        chk("held_rst_repress", 32'(np), 32'd1);
        chk("held_rst_count", 32'(step_count), 32'd1);
        latch_q = 1'b0;
        repeat (4) cyc();

        // free-run at divide 0, then leave run with the button held
        run_div = '0;
        run_mode = 1'b1;
        repeat (4) cyc();
        np = 0;
        for (int i = 0; i < 10; i++) begin
            latch_q = ~latch_q;
            cyc();
            if (step_pulse) np++;
        end
        chk("run_div0_pulses", 32'(np), 32'd10);
        chk("run_running", 32'(running), 32'd1);
        latch_q = 1'b1;
        run_mode = 1'b0;
        repeat (3) cyc();
        count_pulses(10, np);
        chk("run_exit_nopulse", 32'(np), 32'd0);
        chk("run_exit_running", 32'(running), 32'd0);
        latch_q = 1'b0;
        count_pulses(4, np);
        latch_q = 1'b1;
        count_pulses(6, np);
        chk("run_exit_repress", 32'(np), 32'd1);
        latch_q = 1'b0;
        repeat (4) cyc();

        // asynchronous reset in the middle of auto-repeat
        latch_q = 1'b1;
        repeat (15) cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_pulse", 32'(step_pulse), 32'd0);
        chk("rst_async_count", 32'(step_count), 32'd0);
        chk("rst_async_held", 32'(held), 32'd0);
        chk("rst_async_running", 32'(running), 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        count_pulses(15, np);
        chk("rst_rep_nopulse", 32'(np), 32'd0);
        latch_q = 1'b0;
        count_pulses(4, np);
        latch_q = 1'b1;
        count_pulses(6, np);
        chk("rst_rep_repress", 32'(np), 32'd1);
        latch_q = 1'b0;

        // randomized run against the model
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) latch_q = ~latch_q;
            if ($urandom_range(99) == 0) run_mode = ~run_mode;
            if ($urandom_range(39) == 0) repeat_en = ~repeat_en;
            if (!run_mode && $urandom_range(49) == 0) run_div = 24'($urandom_range(4));
            cyc();
            chk($sformatf("rnd%0d_pulse", i), 32'(step_pulse), 32'(m_pulse));
            chk($sformatf("rnd%0d_held", i), 32'(held), 32'(mq[S-1]));
            chk($sformatf("rnd%0d_running", i), 32'(running), 32'(phase == 3));
            chk($sformatf("rnd%0d_count", i), 32'(step_count), 32'(m_count));
        end

        // step counter wrap using fast free-run
        run_div = '0;
        run_mode = 1'b1;
        for (int i = 0; i < 70000 && step_count != 16'hFFFE; i++) cyc();
        chk("wrap_reach", 32'(step_count), 32'hFFFE);
        cyc();
        chk("wrap_ffff", 32'(step_count), 32'hFFFF);
        cyc();
        chk("wrap_0", 32'(step_count), 32'h0);
        cyc();
        chk("wrap_1", 32'(step_count), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
